obstacle_scheduler: RTL
=======================

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter NSLOT, default 4: number of obstacle slots sharing the display.
REQ-002 Parameter OBS_W, default 50; OBS_H, default 75: obstacle box width and height in pixels.
REQ-003 Parameter PLY_W, default 30; PLY_H, default 40: player box width and height in pixels.
REQ-004 Parameter STEP, default 5: pixels scrolled left per tick.
REQ-005 Parameter SPAWN_X, default 700: x of a new obstacle, off-screen right.
REQ-006 Parameter GAP, default 40: ticks between spawn attempts.
REQ-007 clk  in  1  100 MHz system clock, sole clock.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 tick  in  1  one-cycle position-update strobe, synchronous to clk.
REQ-010 start  in  1  one-cycle strobe that begins or restarts a run.
REQ-011 hcount, vcount  in  11 each  current pixel coordinates from the VGA timing controller.
REQ-012 blank  in  1  high outside the visible area.
REQ-013 ply_x, ply_y  in  11 each  player box top-left corner.
REQ-014 figure  out  1  registered: current pixel lies inside an active obstacle.
REQ-015 obs_id  out  2  registered: index of the obstacle that owns the pixel.
REQ-016 active  out  NSLOT  per-slot occupied flags.
REQ-017 hit  out  1  sticky collision flag.
REQ-018 score  out  14  count of obstacles retired, binary, for BCD conversion.
REQ-019 run  out  1  high in state RUN.

Function
REQ-020 FSM states: IDLE, RUN, HALT.
REQ-021 IDLE -> RUN on start; RUN -> HALT on a detected collision; HALT -> RUN on start; no other transitions.
REQ-022 Entering RUN: all slots cleared, score=0, hit=0, spawn counter=0; the LFSR is not reseeded.
REQ-023 Each slot holds valid, x[10:0] and y[10:0].
REQ-024 Slot updates, spawning, retiring and collision checks occur only on a clk edge with tick=1 in RUN; in IDLE and HALT all slot state is frozen.
REQ-025 Scroll, per valid slot on tick: if x <= STEP, clear valid and increment score; otherwise x <= x - STEP.
REQ-026 Score saturates at 9999.
REQ-027 The spawn counter increments on each tick up to GAP and holds at GAP.
REQ-028 On a tick with counter==GAP and at least one free slot, i.e. valid=0 after this tick's retirements: fill the lowest-index free slot with x=SPAWN_X and y=lfsr[7:0]+lfsr[7:1] (range 0..382); reset the counter to 0.
REQ-029 If no slot is free, the spawn is deferred and the counter holds at GAP until a slot frees.
REQ-030 A slot retired on a tick is reusable by a spawn on that same tick.
REQ-031 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; advances once per tick in RUN; reset value 8'hA5; never all-zero.
REQ-032 Collision condition, evaluated on tick against post-scroll positions of valid slots: x <= ply_x+PLY_W and x+OBS_W >= ply_x and y <= ply_y+PLY_H and y+OBS_H >= ply_y.
REQ-033 On collision: hit=1 and FSM -> HALT on the same edge.
REQ-034 All collision arithmetic is 12-bit, with no overflow.
REQ-035 Start takes priority over tick in the same cycle; that tick is ignored.
REQ-036 Pixel path, every clk, 1-cycle latency: figure = ~blank AND some valid slot has x<=hcount<=x+OBS_W and y<=vcount<=y+OBS_H.
REQ-037 When slots overlap, obs_id is the lowest-index covering slot; obs_id=0 when figure=0.
REQ-038 The pixel path runs in all states, so frozen obstacles stay visible in HALT.

Reset
REQ-039 On rst low: state=IDLE; all valid, x and y =0; counter=0; lfsr=8'hA5; score=0; hit=0; figure=0; obs_id=0; run=0.
REQ-040 Reset asserted mid-run aborts immediately; no retirement or score update completes.

Verification
REQ-041 Reset, then start, then 40 ticks -> slot0 valid, x=700, y=lfsr-derived; 41st tick -> x=695.
REQ-042 Single obstacle at x=5, tick -> valid=0, score=1; x=6, tick -> x=1, still valid.
REQ-043 All 4 slots full, counter at GAP -> no spawn and counter holds; next retirement tick -> the freed lowest slot respawns at x=700 on that same tick.
REQ-044 ply at (100,200), obstacle scrolled to x=130, y=180 -> hit=1, run=0; further ticks leave x unchanged; start -> slots cleared, score=0, run=1.
REQ-045 Two slots covering pixel (300,250), blank=0 -> figure=1 and obs_id=lower index one clk later; blank=1 -> figure=0.
REQ-046 Score at 9999, retirement -> score stays 9999.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: scrolls, spawns and retires obstacle slots on tick, flags player
// collisions, and renders a registered per-pixel obstacle overlay.
module obstacle_scheduler #(
  parameter int NSLOT   = 4,
  parameter int OBS_W   = 50,
  parameter int OBS_H   = 75,
  parameter int PLY_W   = 30,
  parameter int PLY_H   = 40,
  parameter int STEP    = 5,
  parameter int SPAWN_X = 700,
  parameter int GAP     = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [10:0]      hcount,
  input  logic [10:0]      vcount,
  input  logic             blank,
  input  logic [10:0]      ply_x,
  input  logic [10:0]      ply_y,
  output logic             figure,
  output logic [1:0]       obs_id,
  output logic [NSLOT-1:0] active,
  output logic             hit,
  output logic [13:0]      score,
  output logic             run
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2;
  localparam int CW = $clog2(GAP + 1);
  localparam logic [CW-1:0] GAP_C = CW'(GAP);
  localparam logic [10:0] STEP_C = 11'(STEP), SPAWN_C = 11'(SPAWN_X);
  localparam logic [11:0] OW = 12'(OBS_W), OH = 12'(OBS_H), PW = 12'(PLY_W), PH = 12'(PLY_H);
  logic [1:0]       state_q, state_d;
  logic [NSLOT-1:0] valid_q, valid_d;
  logic [10:0]      x_q [NSLOT], x_d [NSLOT], y_q [NSLOT], y_d [NSLOT];
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [13:0]      score_q, score_d;
  logic             hit_q, hit_d, figure_q, figure_d, coll, spawned;
  logic [1:0]       obs_id_q, obs_id_d;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    score_d = score_q;
    hit_d   = hit_q;
    coll    = 1'b0;
    spawned = 1'b0;
    cnt_inc = (cnt_q == GAP_C) ? GAP_C : cnt_q + 1'b1;
    if (start) begin
      state_d = RUN;
      valid_d = '0;
      cnt_d   = '0;
      score_d = '0;
      hit_d   = 1'b0;
    end else if (tick && state_q == RUN) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (valid_q[i] && x_q[i] <= STEP_C) begin
          valid_d[i] = 1'b0;
          score_d    = (score_d == 14'd9999) ? score_d : score_d + 14'd1;
        end else if (valid_q[i]) begin
          x_d[i] = x_q[i] - STEP_C;
        end
        coll = coll | (valid_d[i] && ({1'b0, x_d[i]} <= {1'b0, ply_x} + PW) &&
               ({1'b0, x_d[i]} + OW >= {1'b0, ply_x}) && ({1'b0, y_d[i]} <= {1'b0, ply_y} + PH) &&
               ({1'b0, y_d[i]} + OH >= {1'b0, ply_y}));
      end
      // A slot freed by this tick's retirement is already visible as free here
      for (int i = 0; i < NSLOT; i++) begin
        if (!spawned && !valid_d[i] && cnt_inc == GAP_C) begin
          valid_d[i] = 1'b1;
          x_d[i]     = SPAWN_C;
          y_d[i]     = {3'b000, lfsr_q} + {4'b0000, lfsr_q[7:1]};
          spawned    = 1'b1;
        end
      end
      cnt_d   = spawned ? '0 : cnt_inc;
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      hit_d   = coll ? 1'b1 : hit_q;
      state_d = coll ? HALT : state_q;
    end
  end
  always_comb begin
    figure_d = 1'b0;
    obs_id_d = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!blank && valid_q[i] && hcount >= x_q[i] && {1'b0, hcount} <= {1'b0, x_q[i]} + OW &&
          vcount >= y_q[i] && {1'b0, vcount} <= {1'b0, y_q[i]} + OH) begin
        figure_d = 1'b1;
        obs_id_d = 2'(i);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      cnt_q    <= '0;
      lfsr_q   <= 8'hA5;
      score_q  <= '0;
      hit_q    <= 1'b0;
      figure_q <= 1'b0;
      obs_id_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      figure_q <= figure_d;
      obs_id_q <= obs_id_d;
    end
  end
  assign figure = figure_q;
  assign obs_id = obs_id_q;
  assign active = valid_q;
  assign hit    = hit_q;
  assign score  = score_q;
  assign run    = state_q == RUN;
endmodule
